mem_arbiter: RTL

Two-port to one-port memory arbiter for the CPU core. It shares a single sram-like master port between the instruction-fetch port and the data-access port, with one outstanding transaction at a time. It performs fixed-segment virtual-to-physical translation and flags uncached accesses on the master side. It sits between the pipeline's inst/data sram-like ports and the cache/bus bridge.

---
 rtl/mem_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (inst/data) to one-port sram-like master arbiter
// One outstanding transaction; fixed-segment translation and uncached flag at grant.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic        m_uncached,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);

  logic [1:0]  state;
  logic [2:0]  starve_cnt;
  logic        owner;

  logic        is_idle;
  logic        inst_wins;
  logic        grant_inst;
  logic        grant_data;
  logic        grant_any;
  logic        complete;

  logic [31:0] sel_vaddr;
  logic        sel_wr;
  logic [1:0]  sel_size;
  logic [31:0] sel_wdata;
  logic [31:0] sel_paddr;
  logic        sel_uncached;

  assign is_idle    = (state == S_IDLE);
  assign inst_wins  = inst_req && (!data_req || (starve_cnt == STARVE_MAX));
  assign grant_inst = is_idle && inst_wins;
  assign grant_data = is_idle && data_req && !inst_wins;
  assign grant_any  = grant_inst || grant_data;

  assign inst_addr_ok = grant_inst;
  assign data_addr_ok = grant_data;

  // Inst fetches are always word reads; only the data port carries wr/size/wdata.
  always_comb begin
    sel_vaddr = inst_addr;
    sel_wr    = 1'b0;
    sel_size  = 2'b10;
    sel_wdata = 32'h0;
    if (grant_data) begin
      sel_vaddr = data_addr;
      sel_wr    = data_wr;
      sel_size  = data_size;
      sel_wdata = data_wdata;
    end
  end

  // kseg0/kseg1 fold onto the low 512 MiB; everything else is identity mapped.
  always_comb begin
    sel_paddr = sel_vaddr;
    if (sel_vaddr[31:30] == 2'b10) begin
      sel_paddr = {3'b000, sel_vaddr[28:0]};
    end
  end

  assign sel_uncached = (sel_vaddr[31:29] == 3'b101) || (sel_vaddr[31:16] == 16'h1faf);

  assign complete = m_data_ok &&
                    ((state == S_WAIT) || ((state == S_REQ) && m_addr_ok));

  assign m_req        = (state == S_REQ);
  assign inst_data_ok = complete && !owner;
  assign data_data_ok = complete && owner;
  assign inst_rdata   = inst_data_ok ? m_rdata : 32'h0;
  assign data_rdata   = data_data_ok ? m_rdata : 32'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_any) state <= S_REQ;
        end
        S_REQ: begin
          if (m_addr_ok) state <= m_data_ok ? S_IDLE : S_WAIT;
        end
        S_WAIT: begin
          if (m_data_ok) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Counts data grants that overtook a waiting fetch; saturation forces the next grant to inst.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= 3'd0;
    end else if (grant_inst) begin
      starve_cnt <= 3'd0;
    end else if (is_idle && !inst_req) begin
      starve_cnt <= 3'd0;
    end else if (grant_data && inst_req && (starve_cnt != STARVE_MAX)) begin
      starve_cnt <= starve_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner      <= 1'b0;
      m_wr       <= 1'b0;
      m_size     <= 2'b00;
      m_addr     <= 32'h0;
      m_wdata    <= 32'h0;
      m_uncached <= 1'b0;
    end else if (grant_any) begin
      owner      <= grant_data;
      m_wr       <= sel_wr;
      m_size     <= sel_size;
      m_addr     <= sel_paddr;
      m_wdata    <= sel_wdata;
      m_uncached <= sel_uncached;
    end
  end

endmodule
